tiny_fft_ctrl: RTL and testbench

- Frame sequencer for the 4-point, 4-bit FFT datapath.
- Accepts a stream of samples over a valid/ready handshake and writes them into the datapath's input registers by index.
- Waits a programmable settle time, then streams the 4 result bins out over a second valid/ready handshake, with first/last markers.
- Keeps a frame counter and a sticky load-timeout error flag. Sits between the pin-level I/O wrapper and the FFT datapath.

---
 rtl/tiny_fft_pkg.sv | 15 +
 rtl/tiny_fft_gap_timer.sv | 30 +++
 rtl/tiny_fft_ctrl.sv | 157 +++++++++++++++
 tb/tb_tiny_fft_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_fft_pkg.sv
// rtl/tiny_fft_pkg.sv - shared types and default sizes for the tiny FFT frame sequencer
package tiny_fft_pkg;

  localparam int FFT_DATA_W   = 4;
  localparam int FFT_N_POINTS = 4;
  localparam int FFT_IDX_W    = $clog2(FFT_N_POINTS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } fft_state_e;

endpackage

// File: rtl/tiny_fft_gap_timer.sv
// rtl/tiny_fft_gap_timer.sv - idle-gap counter between accepted samples during LOAD
module tiny_fft_gap_timer #(
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((LOAD_TIMEOUT > 0) ? LOAD_TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] count;

  // Fires on the idle cycle whose increment would reach LOAD_TIMEOUT; zero disables it.
  assign expired = (LOAD_TIMEOUT != 0) && enable && !clear && (count == LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tiny_fft_ctrl.sv
// rtl/tiny_fft_ctrl.sv - frame sequencer: loads samples into the FFT datapath and drains its bins
module tiny_fft_ctrl
  import tiny_fft_pkg::*;
#(
  parameter int DATA_W        = FFT_DATA_W,
  parameter int N_POINTS      = FFT_N_POINTS,
  parameter int IDX_W         = FFT_IDX_W,
  parameter int SETTLE_CYCLES = 1,
  parameter int LOAD_TIMEOUT  = 15,
  parameter int FRAME_CNT_W   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   dp_wr_en,
  output logic [IDX_W-1:0]       dp_wr_idx,
  output logic [DATA_W-1:0]      dp_wr_data,
  output logic [IDX_W-1:0]       dp_rd_idx,
  input  logic [DATA_W-1:0]      dp_rd_data,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_first,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   err_timeout
);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_POINTS - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  fft_state_e state, state_nxt;

  logic [IDX_W-1:0]       wr_cnt, wr_cnt_nxt;
  logic [IDX_W-1:0]       rd_cnt, rd_cnt_nxt;
  logic [3:0]             settle_cnt, settle_cnt_nxt;
  logic                   out_valid_nxt;
  logic [DATA_W-1:0]      out_data_nxt;
  logic [FRAME_CNT_W-1:0] frame_cnt_nxt;
  logic                   err_timeout_nxt;

  logic accept;
  logic bin_taken;
  logic gap_clear;
  logic gap_enable;
  logic gap_expired;

  assign in_ready   = (state == ST_IDLE) || (state == ST_LOAD);
  assign accept     = in_valid && in_ready;
  assign dp_wr_en   = accept;
  assign dp_wr_idx  = wr_cnt;
  assign dp_wr_data = in_data;
  assign busy       = (state != ST_IDLE);

  // rd_cnt runs one ahead of the presented bin, so it wraps to 0 while the last bin is shown.
  assign dp_rd_idx  = (state == ST_DRAIN) ? rd_cnt : '0;
  assign bin_taken  = out_valid && out_ready;
  assign out_first  = out_valid && (rd_cnt == IDX_W'(1));
  assign out_last   = out_valid && (rd_cnt == '0);

  assign gap_enable = (state == ST_LOAD);
  assign gap_clear  = accept || (state != ST_LOAD);

  tiny_fft_gap_timer #(
    .LOAD_TIMEOUT(LOAD_TIMEOUT)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (gap_clear),
    .enable (gap_enable),
    .expired(gap_expired)
  );

  always_comb begin
    state_nxt       = state;
    wr_cnt_nxt      = wr_cnt;
    rd_cnt_nxt      = rd_cnt;
    settle_cnt_nxt  = settle_cnt;
    out_valid_nxt   = out_valid;
    out_data_nxt    = out_data;
    frame_cnt_nxt   = frame_cnt;
    err_timeout_nxt = err_timeout;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          wr_cnt_nxt = IDX_W'(1);
          state_nxt  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (wr_cnt == LAST_IDX) begin
            wr_cnt_nxt     = '0;
            settle_cnt_nxt = '0;
            state_nxt      = ST_COMPUTE;
          end else begin
            wr_cnt_nxt = wr_cnt + 1'b1;
          end
        end else if (gap_expired) begin
          wr_cnt_nxt      = '0;
          err_timeout_nxt = 1'b1;
          state_nxt       = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        settle_cnt_nxt = settle_cnt + 4'd1;
        if (settle_cnt == SETTLE_LAST) begin
          out_data_nxt  = dp_rd_data;
          out_valid_nxt = 1'b1;
          rd_cnt_nxt    = IDX_W'(1);
          state_nxt     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bin_taken) begin
          if (rd_cnt == '0) begin
            out_valid_nxt = 1'b0;
            rd_cnt_nxt    = '0;
            frame_cnt_nxt = frame_cnt + 1'b1;
            state_nxt     = ST_IDLE;
          end else begin
            out_data_nxt = dp_rd_data;
            rd_cnt_nxt   = rd_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      settle_cnt  <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      frame_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_cnt      <= wr_cnt_nxt;
      rd_cnt      <= rd_cnt_nxt;
      settle_cnt  <= settle_cnt_nxt;
      out_valid   <= out_valid_nxt;
      out_data    <= out_data_nxt;
      frame_cnt   <= frame_cnt_nxt;
      err_timeout <= err_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_tiny_fft_ctrl.sv
// tb/tb_tiny_fft_ctrl.sv - randomized bench for tiny_fft_ctrl with a datapath model and bin scoreboard
module tb_tiny_fft_ctrl;

  localparam int SETTLE = 1;
  localparam int TMO    = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       dp_wr_en;
  logic [1:0] dp_wr_idx;
  logic [3:0] dp_wr_data;
  logic [1:0] dp_rd_idx;
  logic [3:0] dp_rd_data;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_first;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic [3:0] frame_cnt;
  logic       err_timeout;

  int n_cmp = 0;
  int n_mis = 0;
  int rdy_mode = 2;
  int bins_seen = 0;

  typedef struct {
    logic [3:0] data;
    int         pos;
  } bin_t;

  bin_t       exp_q[$];
  logic [3:0] frame_s [4];
  logic [3:0] dp_mem  [4];

  always #5 clk = ~clk;

  tiny_fft_ctrl #(
    .DATA_W(4), .N_POINTS(4), .IDX_W(2),
    .SETTLE_CYCLES(SETTLE), .LOAD_TIMEOUT(TMO), .FRAME_CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dp_wr_en(dp_wr_en), .dp_wr_idx(dp_wr_idx), .dp_wr_data(dp_wr_data),
    .dp_rd_idx(dp_rd_idx), .dp_rd_data(dp_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_first(out_first), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .frame_cnt(frame_cnt), .err_timeout(err_timeout)
  );

  // Real-valued 4-point transform of the datapath, modulo 16.
  function automatic logic [3:0] ref_bin(input int k, input logic [3:0] a0, input logic [3:0] a1,
                                         input logic [3:0] a2, input logic [3:0] a3);
    int x0, x1, x2, x3, r;
    x0 = a0; x1 = a1; x2 = a2; x3 = a3;
    case (k)
      0:       r = x0 + x1 + x2 + x3;
      1:       r = (x0 - x2) + (x1 - x3);
      2:       r = x0 - x1 + x2 - x3;
      default: r = (x0 - x2) - (x1 - x3);
    endcase
    return 4'(r);
  endfunction

  initial for (int i = 0; i < 4; i++) dp_mem[i] = 4'd0;
  always @(posedge clk) if (dp_wr_en) dp_mem[dp_wr_idx] <= dp_wr_data;
  always_comb dp_rd_data = ref_bin(int'(dp_rd_idx), dp_mem[0], dp_mem[1], dp_mem[2], dp_mem[3]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Bin scoreboard: order, data, markers, stall stability and no input during output.
  logic [3:0] sv_data;
  logic       sv_first, sv_last;
  bit         stalled = 0;
  initial forever begin
    @(negedge clk);
    if (reset && out_valid) begin
      check("no_overlap_in_ready", in_ready, 0);
      if (stalled) begin
        check("stall_data", out_data, sv_data);
        check("stall_first", out_first, sv_first);
        check("stall_last", out_last, sv_last);
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("bin_unexpected", out_data, 32'hFFFF);
        end else begin
          bin_t e;
          e = exp_q.pop_front();
          check("bin_data", out_data, e.data);
          check("bin_first", out_first, e.pos == 0);
          check("bin_last", out_last, e.pos == 3);
          bins_seen++;
        end
        stalled = 0;
      end else begin
        sv_data = out_data; sv_first = out_first; sv_last = out_last;
        stalled = 1;
      end
    end else begin
      stalled = 0;
    end
  end

  task automatic send_sample(input logic [3:0] d, input int idx, input int gap);
    int waited = 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin check("accept_wait", 0, 1); break; end
      @(posedge clk); #1;
    end
    check("wr_en", dp_wr_en, 1);
    check("wr_idx", dp_wr_idx, idx);
    check("wr_data", dp_wr_data, d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < 4; i++) send_sample(frame_s[i], i, $urandom_range(0, max_gap));
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 4; i++) frame_s[i] = 4'($urandom);
  endtask

  task automatic push_ref();
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{ref_bin(k, frame_s[0], frame_s[1], frame_s[2], frame_s[3]), k});
  endtask

  task automatic push_const_1234();
    exp_q.push_back('{4'd10, 0});
    exp_q.push_back('{4'd12, 1});
    exp_q.push_back('{4'd14, 2});
    exp_q.push_back('{4'd0, 3});
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 400);
    check("idle_reached", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 50);
    check("valid_reached", out_valid, 1);
  endtask

  task automatic set_1234();
    frame_s[0] = 4'd1; frame_s[1] = 4'd2; frame_s[2] = 4'd3; frame_s[3] = 4'd4;
  endtask

  initial begin
    int seen0;
    reset = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_dp_wr_en", dp_wr_en, 0);
    check("rst_dp_wr_idx", dp_wr_idx, 0);
    check("rst_dp_wr_data", dp_wr_data, 0);
    check("rst_dp_rd_idx", dp_rd_idx, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_first", out_first, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err", err_timeout, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Reset while bin 2 is presented
    rand_frame();
    send_frame(0);
    push_ref();
    wait_valid();
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk); #1;
    check("mid_bin2_valid", out_valid, 1);
    check("mid_bin2_markers", {out_first, out_last}, 2'b00);
    if (exp_q.size() > 0) check("mid_bin2_data", out_data, exp_q[0].data);
    else check("mid_bin2_queue", exp_q.size(), 2);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed frame 1,2,3,4 with latency and streaming checks
    rdy_mode = 0; out_ready = 1'b1;
    set_1234();
    send_frame(0);
    push_const_1234();
    repeat (SETTLE) begin @(negedge clk); check("latency_early", out_valid, 0); end
    @(negedge clk);
    check("latency_first_valid", out_valid, 1);
    check("latency_first_data", out_data, 10);
    repeat (3) begin @(negedge clk); check("stream_valid", out_valid, 1); end
    @(negedge clk);
    check("frame1_idle", busy, 0);
    check("frame1_in_ready", in_ready, 1);
    check("frame1_cnt", frame_cnt, 1);
    @(posedge clk); #1;

    // Backpressure: 5-cycle stall on bin 1
    rdy_mode = 2; out_ready = 1'b1;
    send_frame(0);
    push_const_1234();
    wait_valid();
    @(posedge clk); #1; out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 12);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle();
    check("bp_frame_cnt", frame_cnt, 2);

    // Load timeout after two samples, then a clean frame
    rdy_mode = 0;
    send_sample(4'($urandom), 0, 0);
    send_sample(4'($urandom), 1, 0);
    repeat (15) @(negedge clk);
    check("tmo_still_load", busy, 1);
    check("tmo_err_early", err_timeout, 0);
    @(negedge clk);
    check("tmo_idle", busy, 0);
    check("tmo_err", err_timeout, 1);
    @(posedge clk); #1;
    rand_frame();
    send_frame(0);
    push_ref();
    wait_idle();
    check("tmo_frame_cnt", frame_cnt, 3);
    check("tmo_err_sticky", err_timeout, 1);

    // Fresh reset, then 16 back-to-back random frames to wrap the counter
    check("queue_empty_pre_wrap", exp_q.size(), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst2_err_cleared", err_timeout, 0);
    check("rst2_frame_cnt", frame_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    rdy_mode = 1;
    seen0 = bins_seen;
    for (int f = 0; f < 16; f++) begin
      rand_frame();
      send_frame(3);
      push_ref();
    end
    wait_idle();
    check("wrap_frame_cnt", frame_cnt, 0);
    check("wrap_bins_seen", bins_seen - seen0, 64);
    check("wrap_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
